key_stepper: RTL and testbench
==============================

Name: key_stepper

Overview:
Parametrised front-panel controller that turns raw active-low pushbuttons into clean control actions.
- Per-key synchronisation and debounce.
- Saturating up/down value with press-and-hold auto-repeat (initial delay, then fixed rate).
- Clear and one-cycle launch pulse that loads a seed.
- Sits between the board KEY inputs and a compute engine (go/done handshake); value feeds the 7-segment display path.

Parameters:
WIDTH, 12, bit width of value and load_value
MAX_VALUE, 255, saturation ceiling for value (must be < 2**WIDTH)
STEP, 1, increment/decrement amount per step
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to change debounced key state (>=1)
REPEAT_DELAY, 25000000, cycles from press event to first auto-repeat step (>=1)
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat steps (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
key_n  in  4  raw buttons, active low: [0]=inc, [1]=dec, [2]=clear, [3]=launch
load_value  in  WIDTH  seed loaded into value on launch
done  in  1  engine completion strobe; clears value
value  out  WIDTH  current saturating value
go  out  1  one-cycle launch pulse
pressed  out  4  debounced key levels, 1 = held

Behaviour:
- Reset (async assert; sync release): value=0, go=0, pressed=0. Sync flops =1 (released). All debounce and repeat counters =0.
- Sync: 2-flop synchroniser per key.
- Debounce: per-key counter counts while the synced level differs from the debounced level, and resets to 0 when they agree. The debounced level flips when the count reaches DEBOUNCE_CYCLES.
- Raw-edge to pressed latency = 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Press event = cycle pressed[k] rises. Release event = cycle it falls.
- Inc/dec state machine, states IDLE, HOLD_DELAY, HOLD_REPEAT:
  - IDLE: on press event of exactly one of inc/dec, take one step and go to HOLD_DELAY with timer=0.
  - HOLD_DELAY: step when timer reaches REPEAT_DELAY, then go to HOLD_REPEAT with timer=0.
  - HOLD_REPEAT: step every REPEAT_PERIOD cycles.
  - Release of the active key, or both inc and dec pressed, returns to IDLE with no step. Re-entry from both-pressed requires a fresh press event.
- Step arithmetic uses WIDTH+1 bits:
  - inc: value = min(value+STEP, MAX_VALUE).
  - dec: value = (value < STEP) ? 0 : value-STEP.
  - Value at a bound holds; never wraps.
- Value update is visible the cycle after the step decision (registered).
- Launch: on a press event of key[3], go=1 for exactly one cycle and value=min(load_value, MAX_VALUE). Holding key[3] gives no further pulses.
- Priority for value writes in one cycle: done > clear (pressed[2] level, continuous) > launch load > inc/dec step. go still pulses on launch even if done or clear wins the value write.
- Inc/dec steps are suppressed while pressed[2]=1. The state machine keeps timing.
- done: value=0 in the cycle after done=1. No effect on go or the state machine.
- Reset mid-hold: state machine to IDLE. After release the key must debounce again before any step.

Optional Feature:
KEY_ACCEL_EN
- Defined: after 8 consecutive HOLD_REPEAT steps, step size becomes 4*STEP (same saturation rules) until the state machine returns to IDLE.
- Undefined: step size is always STEP. No accel counter is synthesised.

Test Plan:
All scenarios use WIDTH=12, MAX_VALUE=255, STEP=1, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=10.
- Reset, then key_n=4'hF -> value=0, go=0, pressed=0. Apply 3-cycle low glitch on key_n[0] -> pressed[0] stays 0, value stays 0.
- Hold key_n[0] low; pressed[0] rises at cycle 6 after the edge; stay held 45 cycles after the press event -> steps at +0,+20,+30,+40; value=4; release -> no further change.
- value=254, hold inc 60 cycles -> value=255 and holds. value=1, tap dec twice -> value=0 and holds, no wrap to 4095.
- load_value=300, press key[3] -> one-cycle go, value=255. Hold key[3] for 100 cycles -> no second go. Pulse done -> value=0 one cycle later.
- Hold inc and dec together -> no step. Hold clear during inc auto-repeat -> value=0 throughout. Same-cycle done and launch -> go=1, value=0.
- With KEY_ACCEL_EN, hold inc from 0 for 150 cycles -> value=1+1+8*1+4*n per remaining repeat, capped at 255. Without it -> value=14.

Source files
------------

// File: rtl/key_stepper.sv
// key_stepper: debounced active-low keys -> saturating value with auto-repeat, clear and launch (optional KEY_ACCEL_EN: 4x step after 8 repeats).
// Latency: raw key edge to pressed is 2+DEBOUNCE_CYCLES cycles; value and go are registered one cycle after the decision.
// Backpressure: none; go is a single-cycle strobe and done is sampled every cycle.
module key_stepper #(
    parameter int WIDTH           = 12,
    parameter int MAX_VALUE       = 255,
    parameter int STEP            = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       key_n,
    input  logic [WIDTH-1:0] load_value,
    input  logic             done,
    output logic [WIDTH-1:0] value,
    output logic             go,
    output logic [3:0]       pressed
);
    localparam int VW   = WIDTH + 1;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [VW-1:0]    MAXV  = VW'(MAX_VALUE);
    localparam logic [WIDTH-1:0] MAXW  = WIDTH'(MAX_VALUE);
    localparam logic [VW-1:0]    STEP1 = VW'(STEP);

    typedef enum logic [1:0] {IDLE, HOLD_DELAY, HOLD_REPEAT} state_t;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_pressed;
    logic [2:0]       r_prev;
    logic [DW-1:0]    r_db_cnt [4];
    state_t           r_state;
    state_t           w_state_nx;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_nx;
    logic             r_dir;
    logic             w_dir_nx;
    logic             w_step;
    logic [WIDTH-1:0] r_value;
    logic             r_go;

    logic [3:0]       w_level;
    logic             w_rise_inc;
    logic             w_rise_dec;
    logic             w_launch;
    logic             w_both;
    logic             w_active_up;
    logic [VW-1:0]    w_stepsz;
    logic [VW-1:0]    w_inc_sum;
    logic [WIDTH-1:0] w_inc_val;
    logic [WIDTH-1:0] w_dec_val;
    logic [WIDTH-1:0] w_load_val;

    assign w_level     = ~r_sync2;
    assign w_rise_inc  = r_pressed[0] & ~r_prev[0];
    assign w_rise_dec  = r_pressed[1] & ~r_prev[1];
    assign w_launch    = r_pressed[3] & ~r_prev[2];
    assign w_both      = r_pressed[0] & r_pressed[1];
    assign w_active_up = r_dir ? r_pressed[1] : r_pressed[0];

    // Counter only runs while the synced level disagrees with the debounced one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 4'hF;
            r_sync2   <= 4'hF;
            r_pressed <= '0;
            r_prev    <= '0;
            for (int k = 0; k < 4; k++) r_db_cnt[k] <= '0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_prev  <= {r_pressed[3], r_pressed[1], r_pressed[0]};
            for (int k = 0; k < 4; k++) begin
                if (w_level[k] == r_pressed[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    r_db_cnt[k]  <= '0;
                    r_pressed[k] <= w_level[k];
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_dir   <= w_dir_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_dir_nx   = r_dir;
        w_step     = 1'b0;
        case (r_state)
            IDLE: begin
                if ((w_rise_inc ^ w_rise_dec) && !w_both) begin
                    w_step     = 1'b1;
                    w_dir_nx   = w_rise_dec;
                    w_state_nx = HOLD_DELAY;
                    w_timer_nx = '0;
                end
            end
            HOLD_DELAY: begin
                if (!w_active_up || w_both) begin
                    w_state_nx = IDLE;
                    w_timer_nx = '0;
                end else if (r_timer == TW'(REPEAT_DELAY - 1)) begin
                    w_step     = 1'b1;
                    w_state_nx = HOLD_REPEAT;
                    w_timer_nx = '0;
                end else begin
                    w_timer_nx = r_timer + 1'b1;
                end
            end
            HOLD_REPEAT: begin
                if (!w_active_up || w_both) begin
                    w_state_nx = IDLE;
                    w_timer_nx = '0;
                end else if (r_timer == TW'(REPEAT_PERIOD - 1)) begin
                    w_step     = 1'b1;
                    w_timer_nx = '0;
                end else begin
                    w_timer_nx = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_timer_nx = '0;
            end
        endcase
    end

`ifdef KEY_ACCEL_EN
    localparam logic [VW-1:0] STEP4 = VW'(4 * STEP);
    logic [3:0] r_acc_cnt;
    logic       w_rep_step;

    assign w_rep_step = w_step && (r_state == HOLD_REPEAT);

    // Counts repeat steps in the current hold; saturates once acceleration kicks in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_acc_cnt <= '0;
        end else if (w_rep_step && (r_acc_cnt != 4'd8)) begin
            r_acc_cnt <= r_acc_cnt + 1'b1;
        end
    end

    assign w_stepsz = (r_acc_cnt == 4'd8) ? STEP4 : STEP1;
`else
    assign w_stepsz = STEP1;
`endif

    assign w_inc_sum  = {1'b0, r_value} + w_stepsz;
    assign w_inc_val  = (w_inc_sum > MAXV) ? MAXW : w_inc_sum[WIDTH-1:0];
    assign w_dec_val  = ({1'b0, r_value} < w_stepsz) ? '0 : (r_value - w_stepsz[WIDTH-1:0]);
    assign w_load_val = ({1'b0, load_value} > MAXV) ? MAXW : load_value;

    // go fires on every launch press, even when done or clear owns the value write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
            r_go    <= 1'b0;
        end else begin
            r_go <= w_launch;
            if (done || r_pressed[2]) begin
                r_value <= '0;
            end else if (w_launch) begin
                r_value <= w_load_val;
            end else if (w_step) begin
                r_value <= w_dir_nx ? w_dec_val : w_inc_val;
            end
        end
    end

    assign value   = r_value;
    assign go      = r_go;
    assign pressed = r_pressed;
endmodule

// File: tb/tb_key_stepper.sv
// Bench for key_stepper: directed key sequences, expected value changes / go pulses / level checks queued and checked by a monitor.
module tb_key_stepper;
    localparam int W = 12;

    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic [3:0]   key_n      = 4'hF;
    logic [W-1:0] load_value = '0;
    logic         done       = 1'b0;
    logic [W-1:0] value;
    logic         go;
    logic [3:0]   pressed;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string        name;
        logic [W-1:0] v;
        logic [3:0]   p;
        logic         g;
    } chk_t;

    chk_t         cq[$];
    logic [W-1:0] vq[$];
    int           gq[$];

    key_stepper #(
        .WIDTH(12), .MAX_VALUE(255), .STEP(1),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(10)
    ) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .load_value(load_value),
        .done(done), .value(value), .go(go), .pressed(pressed)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input logic [W-1:0] v, input logic [3:0] p, input logic g);
        chk_t c;
        c.name = name;
        c.v    = v;
        c.p    = p;
        c.g    = g;
        cq.push_back(c);
    endtask

    task automatic wait_press(input int k);
        int t;
        t = 0;
        while (pressed[k] !== 1'b1 && t < 30) begin
            tick(1);
            t++;
        end
        n_vec++;
        if (pressed[k] !== 1'b1) begin
            n_bad++;
            $display("FAIL press_timeout key%0d: pressed=%b, want bit %0d set within 30 cycles", k, pressed, k);
        end
    endtask

    // Monitor: value changes, go pulses and queued level checks, all sampled mid-cycle.
    initial begin
        logic [W-1:0] prev_val;
        logic         prev_go;
        logic [W-1:0] ev;
        chk_t         c;
        prev_val = '0;
        prev_go  = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (value !== prev_val) begin
                    n_vec++;
                    if (vq.size() == 0) begin
                        n_bad++;
                        $display("FAIL value_change: value=%0d (was %0d), want no change", value, prev_val);
                    end else begin
                        ev = vq.pop_front();
                        if (value !== ev) begin
                            n_bad++;
                            $display("FAIL value_change: value=%0d, want %0d", value, ev);
                        end
                    end
                end
                if (go === 1'b1) begin
                    n_vec++;
                    if (gq.size() == 0) begin
                        n_bad++;
                        $display("FAIL go_pulse: go=1, want no pulse");
                    end else begin
                        void'(gq.pop_front());
                    end
                    if (prev_go === 1'b1) begin
                        n_bad++;
                        $display("FAIL go_width: go high 2 cycles, want 1");
                    end
                end
                while (cq.size() > 0) begin
                    c = cq.pop_front();
                    n_vec++;
                    if (value !== c.v || pressed !== c.p || go !== c.g) begin
                        n_bad++;
                        $display("FAIL %s: value=%0d pressed=%b go=%b, want value=%0d pressed=%b go=%b",
                                 c.name, value, pressed, go, c.v, c.p, c.g);
                    end
                end
            end
            prev_val = value;
            prev_go  = go;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_seq[12];
        logic [W-1:0] fin_val;

        tick(3);
        reset = 1'b0;
        tick(1);
        expect_now("reset", 0, 4'b0000, 1'b0);

        key_n = 4'b1110;
        tick(3);
        key_n = 4'hF;
        tick(10);
        expect_now("glitch", 0, 4'b0000, 1'b0);

        // press-and-hold: steps at press+0, +20, +30, +40
        for (int v = 1; v <= 4; v++) vq.push_back(W'(v));
        key_n = 4'b1110;
        tick(5);
        expect_now("deb_early", 0, 4'b0000, 1'b0);
        tick(1);
        expect_now("deb_edge", 0, 4'b0001, 1'b0);
        tick(1);
        expect_now("step0", 1, 4'b0001, 1'b0);
        tick(19);
        expect_now("pre_delay", 1, 4'b0001, 1'b0);
        tick(1);
        expect_now("delay_step", 2, 4'b0001, 1'b0);
        tick(9);
        expect_now("pre_rep", 2, 4'b0001, 1'b0);
        tick(1);
        expect_now("rep1", 3, 4'b0001, 1'b0);
        tick(10);
        expect_now("rep2", 4, 4'b0001, 1'b0);
        key_n = 4'hF;
        tick(20);
        expect_now("release", 4, 4'b0000, 1'b0);

        // saturation at the top
        vq.push_back(254); gq.push_back(1);
        load_value = 254;
        key_n = 4'b0111;
        wait_press(3);
        tick(1);
        expect_now("load254", 254, 4'b1000, 1'b1);
        key_n = 4'hF;
        tick(10);
        vq.push_back(255);
        key_n = 4'b1110;
        wait_press(0);
        tick(60);
        expect_now("sat_hi", 255, 4'b0001, 1'b0);
        key_n = 4'hF;
        tick(10);

        // saturation at zero
        vq.push_back(1); gq.push_back(1);
        load_value = 1;
        key_n = 4'b0111;
        wait_press(3);
        tick(1);
        expect_now("load1", 1, 4'b1000, 1'b1);
        key_n = 4'hF;
        tick(10);
        vq.push_back(0);
        for (int i = 0; i < 2; i++) begin
            key_n = 4'b1101;
            wait_press(1);
            tick(3);
            key_n = 4'hF;
            tick(10);
        end
        expect_now("sat_lo", 0, 4'b0000, 1'b0);

        // launch clamps the seed; holding launch gives one pulse; done clears
        vq.push_back(255); gq.push_back(1);
        load_value = 300;
        key_n = 4'b0111;
        wait_press(3);
        tick(1);
        expect_now("load300", 255, 4'b1000, 1'b1);
        tick(100);
        expect_now("hold_launch", 255, 4'b1000, 1'b0);
        key_n = 4'hF;
        tick(10);
        vq.push_back(0);
        done = 1'b1;
        expect_now("done_pre", 255, 4'b0000, 1'b0);
        tick(1);
        done = 1'b0;
        expect_now("done_post", 0, 4'b0000, 1'b0);

        // inc and dec together
        key_n = 4'b1100;
        wait_press(0);
        expect_now("both_press", 0, 4'b0011, 1'b0);
        tick(40);
        expect_now("both_hold", 0, 4'b0011, 1'b0);
        key_n = 4'hF;
        tick(10);

        // clear during auto-repeat
        vq.push_back(1); vq.push_back(0);
        key_n = 4'b1110;
        wait_press(0);
        tick(5);
        key_n = 4'b1010;
        tick(6);
        expect_now("clr_pre", 1, 4'b0101, 1'b0);
        tick(1);
        expect_now("clr_hit", 0, 4'b0101, 1'b0);
        tick(40);
        expect_now("clr_hold", 0, 4'b0101, 1'b0);
        key_n = 4'hF;
        tick(10);

        // done and launch in the same cycle
        vq.push_back(200); gq.push_back(1);
        load_value = 200;
        key_n = 4'b0111;
        wait_press(3);
        tick(1);
        expect_now("load200", 200, 4'b1000, 1'b1);
        key_n = 4'hF;
        tick(10);
        vq.push_back(0); gq.push_back(1);
        key_n = 4'b0111;
        wait_press(3);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        expect_now("done_launch", 0, 4'b1000, 1'b1);
        key_n = 4'hF;
        tick(10);

        // long hold from zero: steps at press+0, +20, then every 10 up to +140
`ifdef KEY_ACCEL_EN
        acc_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 14, 18};
        for (int i = 0; i < 12; i++) vq.push_back(W'(acc_seq[i]));
        vq.push_back(22); vq.push_back(26);
        fin_val = 26;
`else
        acc_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
        for (int i = 0; i < 12; i++) vq.push_back(W'(acc_seq[i]));
        vq.push_back(13); vq.push_back(14);
        fin_val = 14;
`endif
        key_n = 4'b1110;
        wait_press(0);
        tick(140);
        key_n = 4'hF;
        tick(20);
        expect_now("long_hold", fin_val, 4'b0000, 1'b0);

        tick(3);
        n_vec++;
        if (vq.size() != 0) begin
            n_bad++;
            $display("FAIL vq_left: %0d value changes missing, want 0", vq.size());
        end
        n_vec++;
        if (gq.size() != 0) begin
            n_bad++;
            $display("FAIL gq_left: %0d go pulses missing, want 0", gq.size());
        end
        n_vec++;
        if (cq.size() != 0) begin
            n_bad++;
            $display("FAIL cq_left: %0d checks unprocessed, want 0", cq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
